sigma_bank_buffer: RTL

Parametrised multi-bank sigma-coefficient buffer for the Reed-Solomon decoder. It sits between the Berlekamp-Massey stage (writer) and the Chien search / Forney stage (reader). NUM_BANKS independent RAM banks form a circular queue of whole codewords, so the writer fills the error-locator polynomial of codeword N+1 while the reader scans codeword N. Banks are handed over by explicit commit/release handshakes, and each bank carries a latched polynomial-length tag.

---
 rtl/sigma_bank_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/sigma_bank_buffer.sv
// Multi-bank sigma-coefficient buffer: a circular queue of whole-codeword RAM banks
// handed from the Berlekamp-Massey writer to the Chien/Forney reader by commit/release.
module sigma_bank_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_len,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_q,
  output logic [ADDR_W:0]   rd_len,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned PTR_W = $clog2(NUM_BANKS);
  localparam int unsigned CNT_W = $clog2(NUM_BANKS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);

  logic [DATA_W-1:0] mem_q [NUM_BANKS][DEPTH];
  logic [ADDR_W:0]   len_q [NUM_BANKS];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_q_q, rd_q_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_underflow_q, err_underflow_d;
  logic              wr_acc, commit_acc, rd_acc, release_acc;

  assign wr_ready      = (count_q != FULL_CNT);
  assign rd_valid      = (count_q != '0);
  assign rd_len        = len_q[rd_ptr_q];
  assign rd_q          = rd_q_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  always_comb begin
    wr_acc      = wr_en && wr_ready;
    commit_acc  = wr_commit && wr_ready;
    rd_acc      = rd_en && rd_valid;
    release_acc = rd_release && rd_valid;

    wr_ptr_d = wr_ptr_q;
    if (commit_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    rd_ptr_d = rd_ptr_q;
    if (release_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    // Commit and release together leave the occupancy unchanged.
    count_d = count_q;
    if (commit_acc && !release_acc) begin
      count_d = count_q + 1'b1;
    end else if (release_acc && !commit_acc) begin
      count_d = count_q - 1'b1;
    end

    rd_q_d = rd_q_q;
    if (rd_acc) begin
      rd_q_d = mem_q[rd_ptr_q][rd_addr];
    end

    err_overflow_d  = err_overflow_q || ((wr_en || wr_commit) && !wr_ready);
    err_underflow_d = err_underflow_q || (rd_release && !rd_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rd_q_q          <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        len_q[b] <= '0;
      end
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rd_q_q          <= rd_q_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      if (commit_acc) begin
        len_q[wr_ptr_q] <= wr_len;
      end
    end
  end

  // Coefficient RAM has no reset so it maps onto plain block RAM.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q][wr_addr] <= wr_data;
    end
  end

endmodule
